// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file access scheduler.
//   XLEN / AW     : data and register-address widths
//   rf_op_e       : operation issued to the register file in a cycle
//   wbuf_entry_t  : one buffered writeback (destination register + data)
package rf_sched_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;

  typedef enum logic [1:0] {
    RF_OP_NOP,
    RF_OP_READ,
    RF_OP_WRITE
  } rf_op_e;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/rf_wbuf_fifo.sv
// Circular write buffer with occupancy count and a youngest-match lookup.
//   clk, reset             : clock, asynchronous active-high reset
//   i_push / i_push_entry  : enqueue an entry (caller guarantees not full)
//   i_pop                  : drop the head entry (caller guarantees not empty)
//   o_head                 : oldest entry
//   o_count/o_empty/o_full : occupancy
//   i_lk_addr1/2           : lookup addresses
//   i_lk_new_valid/entry   : an incoming entry treated as youngest for lookup
//   o_lk_hit1/2, data1/2   : youngest matching data per lookup address
module rf_wbuf_fifo
  import rf_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  wbuf_entry_t       i_push_entry,
  input  logic              i_pop,
  output wbuf_entry_t       o_head,
  output logic [CW-1:0]     o_count,
  output logic              o_empty,
  output logic              o_full,
  input  logic [AW-1:0]     i_lk_addr1,
  input  logic [AW-1:0]     i_lk_addr2,
  input  logic              i_lk_new_valid,
  input  wbuf_entry_t       i_lk_new_entry,
  output logic              o_lk_hit1,
  output logic [XLEN-1:0]   o_lk_data1,
  output logic              o_lk_hit2,
  output logic [XLEN-1:0]   o_lk_data2
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wbuf_entry_t     r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= ptr_inc(r_tail);
      if (i_pop)  r_head <= ptr_inc(r_head);
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_push_entry;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

  // Walk oldest to youngest so later matches override earlier ones,
  // then let the incoming entry override everything.
  always_comb begin
    int            idx_int;
    logic [PW-1:0] idx;
    idx_int    = 0;
    idx        = '0;
    o_lk_hit1  = 1'b0;
    o_lk_data1 = '0;
    o_lk_hit2  = 1'b0;
    o_lk_data2 = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx_int = (int'(r_head) + k) % int'(DEPTH);
      idx     = idx_int[PW-1:0];
      if (k < int'(r_count)) begin
        if (r_mem[idx].rd == i_lk_addr1) begin
          o_lk_hit1  = 1'b1;
          o_lk_data1 = r_mem[idx].data;
        end
        if (r_mem[idx].rd == i_lk_addr2) begin
          o_lk_hit2  = 1'b1;
          o_lk_data2 = r_mem[idx].data;
        end
      end
    end
    if (i_lk_new_valid && (i_lk_new_entry.rd == i_lk_addr1)) begin
      o_lk_hit1  = 1'b1;
      o_lk_data1 = i_lk_new_entry.data;
    end
    if (i_lk_new_valid && (i_lk_new_entry.rd == i_lk_addr2)) begin
      o_lk_hit2  = 1'b1;
      o_lk_data2 = i_lk_new_entry.data;
    end
  end

endmodule

// File: rtl/rf_access_scheduler.sv
// Arbitrates a single-port register file between two-operand decode reads and
// buffered writeback writes; reads are forwarded from the write buffer.
//   clk, reset                      : clock, asynchronous active-high reset
//   i_rd_req_* / o_rd_req_ready     : decode read request handshake
//   o_rd_rsp_valid / o_rd_rsp_data* : read response, one cycle after issue
//   i_wb_* / o_wb_ready             : writeback handshake (rd=0 is dropped)
//   o_rf_* / i_rf_rdata*            : register-file control and read data
//   o_wbuf_count                    : write-buffer occupancy
module rf_access_scheduler
  import rf_sched_pkg::*;
#(
  parameter int unsigned WBUF_DEPTH    = 2,
  parameter int unsigned MAX_RD_STREAK = 4,
  localparam int unsigned CW = $clog2(WBUF_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_rd_req_valid,
  output logic            o_rd_req_ready,
  input  logic [AW-1:0]   i_rd_rs1,
  input  logic [AW-1:0]   i_rd_rs2,
  output logic            o_rd_rsp_valid,
  output logic [XLEN-1:0] o_rd_rsp_data1,
  output logic [XLEN-1:0] o_rd_rsp_data2,
  input  logic            i_wb_valid,
  output logic            o_wb_ready,
  input  logic [AW-1:0]   i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_rf_read_en,
  output logic [AW-1:0]   o_rf_read_addr1,
  output logic [AW-1:0]   o_rf_read_addr2,
  output logic [AW-1:0]   o_rf_write_addr,
  output logic [XLEN-1:0] o_rf_wdata,
  input  logic [XLEN-1:0] i_rf_rdata1,
  input  logic [XLEN-1:0] i_rf_rdata2,
  output logic [CW-1:0]   o_wbuf_count
);

  localparam int unsigned SW = $clog2(MAX_RD_STREAK + 1);

  rf_op_e          w_op;
  wbuf_entry_t     w_head;
  wbuf_entry_t     w_new;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_hit1;
  logic            w_hit2;
  logic [XLEN-1:0] w_fdata1;
  logic [XLEN-1:0] w_fdata2;
  logic [XLEN-1:0] w_rsp_data1;
  logic [XLEN-1:0] w_rsp_data2;

  logic [SW-1:0]   r_streak;
  logic            r_rsp_valid;
  logic            r_fwd_hit1;
  logic            r_fwd_hit2;
  logic [XLEN-1:0] r_fwd_data1;
  logic [XLEN-1:0] r_fwd_data2;
  logic [XLEN-1:0] r_hold1;
  logic [XLEN-1:0] r_hold2;

  assign o_wb_ready     = !reset && !w_full;
  assign o_rd_req_ready = !reset &&
                          (w_empty || (!w_full && (r_streak < SW'(MAX_RD_STREAK))));

  assign w_new.rd   = i_wb_rd;
  assign w_new.data = i_wb_data;
  assign w_push     = i_wb_valid && o_wb_ready && (i_wb_rd != '0);
  assign w_pop      = (w_op == RF_OP_WRITE);

  rf_wbuf_fifo #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk            (clk),
    .reset          (reset),
    .i_push         (w_push),
    .i_push_entry   (w_new),
    .i_pop          (w_pop),
    .o_head         (w_head),
    .o_count        (o_wbuf_count),
    .o_empty        (w_empty),
    .o_full         (w_full),
    .i_lk_addr1     (i_rd_rs1),
    .i_lk_addr2     (i_rd_rs2),
    .i_lk_new_valid (w_push),
    .i_lk_new_entry (w_new),
    .o_lk_hit1      (w_hit1),
    .o_lk_data1     (w_fdata1),
    .o_lk_hit2      (w_hit2),
    .o_lk_data2     (w_fdata2)
  );

  always_comb begin
    w_op            = RF_OP_NOP;
    o_rf_read_en    = 1'b0;
    o_rf_read_addr1 = i_rd_rs1;
    o_rf_read_addr2 = i_rd_rs2;
    o_rf_write_addr = '0;
    o_rf_wdata      = w_head.data;
    if (!reset) begin
      if (i_rd_req_valid && o_rd_req_ready) w_op = RF_OP_READ;
      else if (!w_empty)                    w_op = RF_OP_WRITE;
    end
    unique case (w_op)
      RF_OP_READ:  o_rf_read_en    = 1'b1;
      RF_OP_WRITE: o_rf_write_addr = w_head.rd;
      default:     ;
    endcase
  end

  // Streak counts reads that bypass a non-empty buffer; pre-enqueue state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_empty || (w_op == RF_OP_WRITE)) begin
      r_streak <= '0;
    end else if ((w_op == RF_OP_READ) && (r_streak != SW'(MAX_RD_STREAK))) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  // Forward snapshot at issue; rs=0 is forced to a zero "hit".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_fwd_hit1  <= 1'b0;
      r_fwd_hit2  <= 1'b0;
      r_fwd_data1 <= '0;
      r_fwd_data2 <= '0;
    end else begin
      r_rsp_valid <= (w_op == RF_OP_READ);
      if (w_op == RF_OP_READ) begin
        r_fwd_hit1  <= w_hit1 || (i_rd_rs1 == '0);
        r_fwd_hit2  <= w_hit2 || (i_rd_rs2 == '0);
        r_fwd_data1 <= (i_rd_rs1 == '0) ? '0 : w_fdata1;
        r_fwd_data2 <= (i_rd_rs2 == '0) ? '0 : w_fdata2;
      end
    end
  end

  assign w_rsp_data1 = r_fwd_hit1 ? r_fwd_data1 : i_rf_rdata1;
  assign w_rsp_data2 = r_fwd_hit2 ? r_fwd_data2 : i_rf_rdata2;

  // Register file read data is only meaningful on the response cycle, so the
  // response is captured there and held afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold1 <= '0;
      r_hold2 <= '0;
    end else if (r_rsp_valid) begin
      r_hold1 <= w_rsp_data1;
      r_hold2 <= w_rsp_data2;
    end
  end

  assign o_rd_rsp_valid = r_rsp_valid;
  assign o_rd_rsp_data1 = r_rsp_valid ? w_rsp_data1 : r_hold1;
  assign o_rd_rsp_data2 = r_rsp_valid ? w_rsp_data2 : r_hold2;

endmodule

// File: doc/rf_access_scheduler.md
Name: rf_access_scheduler

Overview:
- Arbitrates the single-port 32x64 register file between the decode stage (two-operand reads) and the writeback stage (single writes).
- The register file performs at most one operation per cycle: a read when read_en=1, otherwise a write when the write address is non-zero.
- Writeback data goes through a small write buffer. Reads are forwarded from that buffer, so no stale value is ever returned.
- The block sits between the pipeline and the register file and owns all of the register file's control inputs.

Parameters:
- XLEN, 64, data width.
- AW, 5, register address width.
- WBUF_DEPTH, 2, write-buffer entries (minimum 1).
- MAX_RD_STREAK, 4, maximum consecutive reads granted while the write buffer is non-empty.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rd_req_valid  in  1  decode read request
- rd_req_ready  out  1  read request accepted this cycle when valid&ready
- rd_rs1  in  AW  source register 1
- rd_rs2  in  AW  source register 2
- rd_rsp_valid  out  1  read data valid; no backpressure
- rd_rsp_data1  out  XLEN  operand 1
- rd_rsp_data2  out  XLEN  operand 2
- wb_valid  in  1  writeback request
- wb_ready  out  1  write accepted when valid&ready
- wb_rd  in  AW  destination register
- wb_data  in  XLEN  write data
- rf_read_en  out  1  to register file read_en
- rf_read_addr1  out  AW  to data_read_1
- rf_read_addr2  out  AW  to data_read_2
- rf_write_addr  out  AW  to write_en (the write address; 0 means no write)
- rf_wdata  out  XLEN  to data_in
- rf_rdata1  in  XLEN  from data_out_1
- rf_rdata2  in  XLEN  from data_out_2
- wbuf_count  out  $clog2(WBUF_DEPTH+1)  buffer occupancy

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: rd_rsp_valid=0, rd_rsp_data1/2=0, wbuf_count=0, streak=0, buffer emptied.
- While reset is high: rf_read_en=0, rf_write_addr=0, rd_req_ready=0, wb_ready=0.
- wb_ready = !full. It must not depend on wb_valid.
- Write accepted with wb_rd=0: the handshake completes and the entry is dropped (not enqueued).
- rd_req_ready = empty OR (!full AND streak<MAX_RD_STREAK). It must not depend on rd_req_valid.
- Per-cycle operation, combinational from current state:
  - READ when rd_req_valid&rd_req_ready: rf_read_en=1, addresses = rs1/rs2, rf_write_addr=0.
  - Else WRITE if the buffer is non-empty: rf_read_en=0, rf_write_addr/rf_wdata = head entry; head is popped at the clock edge.
  - Else NOP: rf_read_en=0, rf_write_addr=0.
- Streak counter:
  - Increments on READ while the buffer is non-empty (before any same-cycle enqueue), saturating at MAX_RD_STREAK.
  - Clears on WRITE or when the buffer is empty.
- Full buffer: rd_req_ready=0, so a WRITE is issued every cycle until the buffer is no longer full.
- Enqueue and pop in the same cycle are both allowed; count is unchanged.
- Read latency is 1 cycle. rd_rsp_valid is high in the cycle after READ and only then.
- rd_rsp_data is registered on the response cycle from rf_rdata, or from the forward snapshot.
- Forward snapshot, captured at READ issue:
  - For each rs, the youngest matching entry among the buffer contents plus a same-cycle accepted write (same-cycle write is youngest).
  - A matching entry overrides rf_rdata.
  - rs=0 always returns 0.
- rf_rdata is sampled only on response cycles; register-file outputs are don't-care otherwise.
- Writes popped before the READ cycle are already in the register file; no forwarding is needed for them.
- rd_rsp_data holds its last value when rd_rsp_valid=0.
- Reset mid-operation: buffered writes are discarded and a pending response is cancelled (rd_rsp_valid=0 next cycle).
- No operation is issued in the cycle reset deasserts if the buffer is empty and there is no request.

Decomposition:
- Package rf_sched_pkg:
  - XLEN and AW constants.
  - Op enum {RF_OP_NOP, RF_OP_READ, RF_OP_WRITE}.
  - Write-buffer entry struct {rd, data}.
- One sub-module, rf_wbuf_fifo:
  - WBUF_DEPTH circular FIFO with count.
  - Provides a youngest-match lookup on two addresses, including an incoming entry.
- Arbitration, streak counter and response registers stay in the top module.

Test Plan:
- Reset, then read rs1=5, rs2=6 -> next cycle rd_rsp_valid=1, data1=0, data2=0; rf_write_addr=0 throughout.
- Write x5=0xDEADBEEF at cycle 0, read rs1=5 at cycle 1 -> READ issued at cycle 1 with the write still buffered, rsp data1=0xDEADBEEF at cycle 2; WRITE of x5 at cycle 2; re-read at cycle 4 returns 0xDEADBEEF from the register file.
- Write x7=0x11 then x7=0x22 (buffer full), read x7 in the same cycle as a third write x7=0x33 -> wb_ready=0, rd_req_ready=0, two WRITE cycles; read then returns 0x33 if the write was accepted, else 0x22.
- wb_rd=0, data=0x1234 -> wb_ready=1, wbuf_count stays 0; read rs1=0 -> 0.
- One buffered write plus continuous rd_req_valid for 7 cycles with MAX_RD_STREAK=4 -> 4 READs, 1 WRITE (rd_req_ready=0), then 2 READs; wbuf_count ends at 0.
- 2 buffered entries and a response pending, assert reset -> rd_rsp_valid=0, wbuf_count=0, no WRITE issued after reset.
